// File: rtl/sync_recover_pkg.sv
// Shared definitions for the sync recovery / blank decode block.
// Holds the default raster timing of the current core, the counter type
// and a small window-decode helper used by the blank logic.
package sync_recover_pkg;

    // Default timing for the current core
    localparam int DEF_PIX_DIV     = 16;
    localparam int DEF_CNT_W       = 10;
    localparam int DEF_COLOR_W     = 4;
    localparam int DEF_H_ACT_START = 34;
    localparam int DEF_H_ACT_END   = 214;
    localparam int DEF_V_ACT_START = 25;
    localparam int DEF_V_ACT_END   = 255;
    localparam int DEF_LOCK_FRAMES = 4;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

    // True when start <= cnt < stop
    function automatic logic in_window(input int cnt, input int start, input int stop);
        return (cnt >= start) && (cnt < stop);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Ports:
//   CLK_VIDEO  clock
//   reset      asynchronous active-high reset (count -> 0)
//   en         advance by one unless already at MAX
//   clr        synchronous clear, wins over en
//   cnt        registered count
//   cnt_nxt    value cnt takes on the next edge
//   sat        cnt == MAX
module sat_counter #(
    parameter int W   = 10,
    parameter int MAX = (1 << W) - 1
) (
    input  logic         CLK_VIDEO,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         sat
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign sat = (cnt == MAX_V);

    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (en && !sat)
            cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/sync_recover_blank.sv
// Recovers raster position from raw core hs/vs and produces registered,
// normalised sync, blanking, data-enable and blank-gated colour for the
// video mixer. Also measures line length / frame height and flags lock.
// Ports:
//   CLK_VIDEO, reset          video clock, async active-high reset
//   hs_in, vs_in              raw core syncs (polarity set by HS_POL/VS_POL)
//   r_in, g_in, b_in          core colour
//   ce_pix                    one-cycle pixel enable every PIX_DIV clocks
//   HSync, VSync              normalised active-high syncs
//   HBlank, VBlank, de        blanking and data enable
//   r_out, g_out, b_out       colour aligned to the blanks
//   h_cnt, v_cnt              current pixel and line
//   line_len, frame_lines     length of last complete line / frame
//   locked                    raster height stable for LOCK_FRAMES frames
module sync_recover_blank
    import sync_recover_pkg::*;
#(
    parameter int PIX_DIV     = DEF_PIX_DIV,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int H_ACT_END   = DEF_H_ACT_END,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int V_ACT_END   = DEF_V_ACT_END,
    parameter int HS_POL      = 1,
    parameter int VS_POL      = 1,
    parameter int BLANK_ZERO  = 1,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic               CLK_VIDEO,
    input  logic               reset,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic               ce_pix,
    output logic               HSync,
    output logic               VSync,
    output logic               HBlank,
    output logic               VBlank,
    output logic               de,
    output logic [COLOR_W-1:0] r_out,
    output logic [COLOR_W-1:0] g_out,
    output logic [COLOR_W-1:0] b_out,
    output logic [CNT_W-1:0]   h_cnt,
    output logic [CNT_W-1:0]   v_cnt,
    output logic [CNT_W-1:0]   line_len,
    output logic [CNT_W-1:0]   frame_lines,
    output logic               locked
);

    localparam int   PIX_W  = $clog2(PIX_DIV);
    localparam int   LOCK_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);
    localparam logic HS_INV = (HS_POL == 0);
    localparam logic VS_INV = (VS_POL == 0);

    function automatic logic [COLOR_W-1:0] blank_gate(input logic [COLOR_W-1:0] c,
                                                      input logic blank);
        return (BLANK_ZERO != 0 && blank) ? '0 : c;
    endfunction

    // Pixel divider
    logic [PIX_W-1:0] pix;
    logic             tick;

    assign tick = (pix == PIX_LAST);

    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset)
            pix <= '0;
        else if (tick)
            pix <= '0;
        else
            pix <= pix + 1'b1;
    end

    // Edge detect at pixel granularity. vs is only looked at on an hs rise,
    // so a vs pulse between line starts never restarts the frame.
    logic hs_n, vs_n;
    logic hs_prev, vs_prev;
    logic hs_rise, vs_rise;

    assign hs_n    = hs_in ^ HS_INV;
    assign vs_n    = vs_in ^ VS_INV;
    assign hs_rise = tick & hs_n & ~hs_prev;
    assign vs_rise = hs_rise & vs_n & ~vs_prev;

    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            if (tick)
                hs_prev <= hs_n;
            if (hs_rise)
                vs_prev <= vs_n;
        end
    end

    // Position counters
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             h_sat, v_sat;

    sat_counter #(.W(CNT_W)) u_h_cnt (
        .CLK_VIDEO (CLK_VIDEO),
        .reset     (reset),
        .en        (tick & ~hs_rise),
        .clr       (hs_rise),
        .cnt       (h_cnt),
        .cnt_nxt   (h_nxt),
        .sat       (h_sat)
    );

    sat_counter #(.W(CNT_W)) u_v_cnt (
        .CLK_VIDEO (CLK_VIDEO),
        .reset     (reset),
        .en        (hs_rise & ~vs_rise),
        .clr       (vs_rise),
        .cnt       (v_cnt),
        .cnt_nxt   (v_nxt),
        .sat       (v_sat)
    );

    // Lock tracking: counts consecutive frames whose height repeats the
    // previous one. A saturated v_cnt means vs has gone away, so drop lock.
    logic [CNT_W-1:0]  h_len, v_len;
    logic              height_match;
    logic [LOCK_W-1:0] lock_cnt, lock_nxt;

    assign h_len        = h_cnt + 1'b1;
    assign v_len        = v_cnt + 1'b1;
    assign height_match = (v_len == frame_lines);

    sat_counter #(.W(LOCK_W), .MAX(LOCK_FRAMES)) u_lock_cnt (
        .CLK_VIDEO (CLK_VIDEO),
        .reset     (reset),
        .en        (vs_rise & height_match),
        .clr       ((vs_rise & ~height_match) | v_sat),
        .cnt       (lock_cnt),
        .cnt_nxt   (lock_nxt),
        .sat       (locked)
    );

    logic unused_sigs;
    assign unused_sigs = ^{h_sat, lock_cnt, lock_nxt};

    // Blank decode from the counter values being loaded on this tick, so
    // every output moves on the same edge as h_cnt/v_cnt.
    logic hblank_nxt, vblank_nxt, blank_nxt;

    assign hblank_nxt = ~in_window(int'(h_nxt), H_ACT_START, H_ACT_END);
    assign vblank_nxt = ~in_window(int'(v_nxt), V_ACT_START, V_ACT_END);
    assign blank_nxt  = hblank_nxt | vblank_nxt;

    // Output register stage
    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            ce_pix      <= 1'b0;
            HSync       <= 1'b0;
            VSync       <= 1'b0;
            HBlank      <= 1'b1;
            VBlank      <= 1'b1;
            de          <= 1'b0;
            r_out       <= '0;
            g_out       <= '0;
            b_out       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            ce_pix <= tick;
            if (tick) begin
                HSync  <= hs_n;
                VSync  <= vs_n;
                HBlank <= hblank_nxt;
                VBlank <= vblank_nxt;
                de     <= ~blank_nxt;
                r_out  <= blank_gate(r_in, blank_nxt);
                g_out  <= blank_gate(g_in, blank_nxt);
                b_out  <= blank_gate(b_in, blank_nxt);
            end
            if (hs_rise)
                line_len <= h_len;
            if (vs_rise)
                frame_lines <= v_len;
        end
    end

endmodule

// File: tb/tb_sync_recover_blank.sv
module tb_sync_recover_blank;

    logic       clk;
    logic       reset;
    logic       hs, vs;
    logic       hs_lo, vs_lo;
    logic [3:0] r_in, g_in, b_in;

    int vectors;
    int miscompares;

    assign hs_lo = ~hs;
    assign vs_lo = ~vs;

    // Main instance: active-high syncs, fast divider
    logic       ce_m, hs_m, vs_m, hb_m, vb_m, de_m, lk_m;
    logic [3:0] r_m, g_m, b_m;
    logic [9:0] hc_m, vc_m, ll_m, fl_m;

    // Active-low sync instance fed with inverted syncs
    logic       ce_n, hs_n, vs_n, hb_n, vb_n, de_n, lk_n;
    logic [3:0] r_n, g_n, b_n;
    logic [9:0] hc_n, vc_n, ll_n, fl_n;

    // Default-parameter instance, used for divider timing
    logic       ce_d, hs_d, vs_d, hb_d, vb_d, de_d, lk_d;
    logic [3:0] r_d, g_d, b_d;
    logic [9:0] hc_d, vc_d, ll_d, fl_d;

    sync_recover_blank #(.PIX_DIV(2)) dut (
        .CLK_VIDEO(clk), .reset(reset), .hs_in(hs), .vs_in(vs),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .ce_pix(ce_m), .HSync(hs_m), .VSync(vs_m), .HBlank(hb_m), .VBlank(vb_m), .de(de_m),
        .r_out(r_m), .g_out(g_m), .b_out(b_m), .h_cnt(hc_m), .v_cnt(vc_m),
        .line_len(ll_m), .frame_lines(fl_m), .locked(lk_m)
    );

    sync_recover_blank #(.PIX_DIV(2), .HS_POL(0), .VS_POL(0)) dut_n (
        .CLK_VIDEO(clk), .reset(reset), .hs_in(hs_lo), .vs_in(vs_lo),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .ce_pix(ce_n), .HSync(hs_n), .VSync(vs_n), .HBlank(hb_n), .VBlank(vb_n), .de(de_n),
        .r_out(r_n), .g_out(g_n), .b_out(b_n), .h_cnt(hc_n), .v_cnt(vc_n),
        .line_len(ll_n), .frame_lines(fl_n), .locked(lk_n)
    );

    sync_recover_blank dut_d (
        .CLK_VIDEO(clk), .reset(reset), .hs_in(hs), .vs_in(vs),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .ce_pix(ce_d), .HSync(hs_d), .VSync(vs_d), .HBlank(hb_d), .VBlank(vb_d), .de(de_d),
        .r_out(r_d), .g_out(g_d), .b_out(b_d), .h_cnt(hc_d), .v_cnt(vc_d),
        .line_len(ll_d), .frame_lines(fl_d), .locked(lk_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    // Present one pixel of hs/vs and return just after the tick edge that
    // consumed it, while ce_pix is high.
    task automatic pix(input logic h, input logic v);
        int n;
        hs = h;
        vs = v;
        n  = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ce_m && n < 8);
        if (!ce_m) begin
            vectors++;
            miscompares++;
            $display("FAIL pix_timeout ce_pix=%b required 1 within 8 clocks", ce_m);
            summary();
            $finish;
        end
    endtask

    task automatic do_reset();
        hs    = 1'b0;
        vs    = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        int first_m, first_d, second_d;
        logic d17;
        do_reset();
        repeat (3) pix(1'b0, 1'b0);
        pix(1'b1, 1'b1);
        pix(1'b1, 1'b0);
        vectors++; if (hc_m !== 10'd1) begin miscompares++; $display("FAIL pre_h_cnt got %0d want 1", hc_m); end
        vectors++; if (ll_m !== 10'd4) begin miscompares++; $display("FAIL pre_line_len got %0d want 4", ll_m); end
        vectors++; if (fl_m !== 10'd1) begin miscompares++; $display("FAIL pre_frame_lines got %0d want 1", fl_m); end
        vectors++; if (hs_m !== 1'b1) begin miscompares++; $display("FAIL pre_hsync got %b want 1", hs_m); end
        // Assert reset between clock edges: outputs must clear without an edge
        #3 reset = 1'b1;
        #1;
        vectors++; if (ce_m !== 1'b0) begin miscompares++; $display("FAIL rst_ce_pix got %b want 0", ce_m); end
        vectors++; if ({hs_m, vs_m} !== 2'b00) begin miscompares++; $display("FAIL rst_syncs got %b want 00", {hs_m, vs_m}); end
        vectors++; if ({hb_m, vb_m, de_m} !== 3'b110) begin miscompares++; $display("FAIL rst_blanks got %b want 110", {hb_m, vb_m, de_m}); end
        vectors++; if ({r_m, g_m, b_m} !== 12'h000) begin miscompares++; $display("FAIL rst_rgb got %h want 000", {r_m, g_m, b_m}); end
        vectors++; if ({hc_m, vc_m} !== 20'd0) begin miscompares++; $display("FAIL rst_counts got %0d/%0d want 0/0", hc_m, vc_m); end
        vectors++; if ({ll_m, fl_m} !== 20'd0) begin miscompares++; $display("FAIL rst_measure got %0d/%0d want 0/0", ll_m, fl_m); end
        vectors++; if (lk_m !== 1'b0) begin miscompares++; $display("FAIL rst_locked got %b want 0", lk_m); end
        vectors++; if ({hb_d, vb_d} !== 2'b11) begin miscompares++; $display("FAIL rst_blanks_default got %b want 11", {hb_d, vb_d}); end
        // Release just after an edge and count clocks to the first ce_pix
        @(posedge clk);
        #1 reset = 1'b0;
        first_m = 0; first_d = 0; second_d = 0; d17 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ce_m && first_m == 0) first_m = k;
            if (k == 17) d17 = ce_d;
            if (ce_d && first_d != 0 && second_d == 0) second_d = k;
            if (ce_d && first_d == 0) first_d = k;
        end
        vectors++; if (first_d != 16) begin miscompares++; $display("FAIL first_ce_default got %0d want 16", first_d); end
        vectors++; if (second_d != 32) begin miscompares++; $display("FAIL second_ce_default got %0d want 32", second_d); end
        vectors++; if (d17 !== 1'b0) begin miscompares++; $display("FAIL ce_width_default got %b want 0", d17); end
        vectors++; if (first_m != 2) begin miscompares++; $display("FAIL first_ce_div2 got %0d want 2", first_m); end
    endtask

    // 228-pixel lines: line length, horizontal window and colour gating
    task automatic test_line();
        logic exp_hb;
        do_reset();
        for (int y = 0; y < 27; y++) begin
            for (int x = 0; x < 228; x++) begin
                pix(x == 0, (x == 0) && (y == 0));
                if (x == 0 && y == 0) begin
                    vectors++; if (ll_m !== 10'd1) begin miscompares++; $display("FAIL first_line_len got %0d want 1", ll_m); end
                end
                if (x == 0 && (y == 1 || y == 26)) begin
                    vectors++; if (ll_m !== 10'd228) begin miscompares++; $display("FAIL line_len y=%0d got %0d want 228", y, ll_m); end
                    vectors++; if (ll_n !== 10'd228) begin miscompares++; $display("FAIL line_len_lowpol y=%0d got %0d want 228", y, ll_n); end
                end
                if (y == 24 && x == 34) begin
                    vectors++; if ({vb_m, de_m, r_m} !== {1'b1, 1'b0, 4'h0}) begin miscompares++; $display("FAIL line24 vb/de/r got %b/%b/%h want 1/0/0", vb_m, de_m, r_m); end
                end
                if (y == 25) begin
                    exp_hb = (x < 34) || (x >= 214);
                    vectors++; if (hc_m !== 10'(x)) begin miscompares++; $display("FAIL h_cnt x=%0d got %0d", x, hc_m); end
                    vectors++; if (hc_n !== 10'(x)) begin miscompares++; $display("FAIL h_cnt_lowpol x=%0d got %0d", x, hc_n); end
                    vectors++; if (hb_m !== exp_hb) begin miscompares++; $display("FAIL hblank x=%0d got %b want %b", x, hb_m, exp_hb); end
                    vectors++; if (de_m !== !exp_hb) begin miscompares++; $display("FAIL de x=%0d got %b want %b", x, de_m, !exp_hb); end
                    vectors++; if (r_m !== (exp_hb ? 4'h0 : 4'hA)) begin miscompares++; $display("FAIL r_out x=%0d got %h", x, r_m); end
                    if (x == 34 || x == 214) begin
                        vectors++; if ({vb_m, vc_m} !== {1'b0, 10'd25}) begin miscompares++; $display("FAIL line25 vb/v got %b/%0d want 0/25", vb_m, vc_m); end
                        vectors++; if ({g_m, b_m} !== (x == 34 ? 8'h53 : 8'h00)) begin miscompares++; $display("FAIL gb_out x=%0d got %h", x, {g_m, b_m}); end
                    end
                end
            end
        end
    endtask

    // 4-pixel lines, one 262-line frame: vertical window and frame height
    task automatic test_frame();
        do_reset();
        for (int y = 0; y <= 262; y++) begin
            pix(1'b1, (y == 0) || (y == 262));
            if (y == 0) begin
                vectors++; if ({vs_m, vc_m, fl_m} !== {1'b1, 10'd0, 10'd1}) begin miscompares++; $display("FAIL frame_start vs/v/fl got %b/%0d/%0d want 1/0/1", vs_m, vc_m, fl_m); end
            end
            if (y == 1) begin
                vectors++; if (vs_m !== 1'b0) begin miscompares++; $display("FAIL vsync_line1 got %b want 0", vs_m); end
            end
            if (y == 24 || y == 25 || y == 254 || y == 255) begin
                vectors++; if (vc_m !== 10'(y)) begin miscompares++; $display("FAIL v_cnt y=%0d got %0d", y, vc_m); end
                vectors++; if (vb_m !== ((y < 25) || (y >= 255))) begin miscompares++; $display("FAIL vblank y=%0d got %b", y, vb_m); end
            end
            if (y == 262) begin
                vectors++; if (fl_m !== 10'd262) begin miscompares++; $display("FAIL frame_lines got %0d want 262", fl_m); end
                vectors++; if (fl_n !== 10'd262) begin miscompares++; $display("FAIL frame_lines_lowpol got %0d want 262", fl_n); end
                vectors++; if (vc_m !== 10'd0) begin miscompares++; $display("FAIL v_cnt_wrap got %0d want 0", vc_m); end
            end
            if (y < 262) repeat (3) pix(1'b0, 1'b0);
        end
    endtask

    // Lock acquisition, loss on a height change, and reacquisition
    task automatic test_lock();
        int   heights [11];
        logic exp_lk  [12];
        heights = '{262, 262, 262, 262, 262, 263, 262, 262, 262, 262, 262};
        exp_lk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int f = 0; f < 12; f++) begin
            pix(1'b1, 1'b1);
            vectors++; if (lk_m !== exp_lk[f]) begin miscompares++; $display("FAIL locked frame=%0d got %b want %b", f, lk_m, exp_lk[f]); end
            if (f > 0) begin
                vectors++; if (fl_m !== 10'(heights[f-1])) begin miscompares++; $display("FAIL lock_frame_lines frame=%0d got %0d want %0d", f, fl_m, heights[f-1]); end
            end
            if (f < 11) begin
                repeat (3) pix(1'b0, 1'b0);
                for (int l = 1; l < heights[f]; l++) begin
                    pix(1'b1, 1'b0);
                    repeat (3) pix(1'b0, 1'b0);
                end
                if (f == 5) begin
                    vectors++; if (lk_m !== 1'b1) begin miscompares++; $display("FAIL locked_holds got %b want 1", lk_m); end
                end
            end
        end
    endtask

    // Continues from a locked raster: vs disappears, v_cnt saturates, lock drops
    task automatic test_vsat();
        repeat (3) pix(1'b0, 1'b0);
        for (int y = 1; y < 1030; y++) begin
            pix(1'b1, 1'b0);
            if (y == 1022) begin
                vectors++; if ({vc_m, lk_m} !== {10'd1022, 1'b1}) begin miscompares++; $display("FAIL vsat_pre v/lk got %0d/%b want 1022/1", vc_m, lk_m); end
            end
            if (y == 1023) begin
                vectors++; if ({vc_m, vb_m} !== {10'd1023, 1'b1}) begin miscompares++; $display("FAIL vsat_hit v/vb got %0d/%b want 1023/1", vc_m, vb_m); end
            end
            if (y == 1029) begin
                vectors++; if ({vc_m, lk_m} !== {10'd1023, 1'b0}) begin miscompares++; $display("FAIL vsat_hold v/lk got %0d/%b want 1023/0", vc_m, lk_m); end
            end
            repeat (3) pix(1'b0, 1'b0);
        end
    endtask

    // hs and vs rising in the same pixel; vs pulse between line starts ignored
    task automatic test_simul();
        do_reset();
        for (int l = 1; l <= 5; l++) begin
            pix(1'b1, 1'b0);
            repeat (3) pix(1'b0, 1'b0);
        end
        vectors++; if ({hc_m, vc_m, fl_m} !== {10'd3, 10'd5, 10'd0}) begin miscompares++; $display("FAIL pre_simul h/v/fl got %0d/%0d/%0d want 3/5/0", hc_m, vc_m, fl_m); end
        pix(1'b1, 1'b1);
        vectors++; if ({hc_m, vc_m} !== 20'd0) begin miscompares++; $display("FAIL simul h/v got %0d/%0d want 0/0", hc_m, vc_m); end
        vectors++; if ({fl_m, ll_m} !== {10'd6, 10'd4}) begin miscompares++; $display("FAIL simul fl/ll got %0d/%0d want 6/4", fl_m, ll_m); end
        vectors++; if ({hs_m, vs_m} !== 2'b11) begin miscompares++; $display("FAIL simul syncs got %b want 11", {hs_m, vs_m}); end
        repeat (3) pix(1'b0, 1'b0);
        pix(1'b1, 1'b0);
        pix(1'b0, 1'b1);
        pix(1'b0, 1'b0);
        pix(1'b0, 1'b0);
        pix(1'b1, 1'b0);
        vectors++; if ({vc_m, fl_m} !== {10'd2, 10'd6}) begin miscompares++; $display("FAIL vs_without_hs v/fl got %0d/%0d want 2/6", vc_m, fl_m); end
    endtask

    // hs stops: h_cnt saturates at 1023 and does not wrap
    task automatic test_hsat();
        do_reset();
        pix(1'b1, 1'b0);
        for (int n = 1; n <= 1100; n++) begin
            pix(1'b0, 1'b0);
            if (n == 1022) begin
                vectors++; if (hc_m !== 10'd1022) begin miscompares++; $display("FAIL hsat_pre got %0d want 1022", hc_m); end
            end
            if (n == 1023 || n == 1100) begin
                vectors++; if (hc_m !== 10'd1023) begin miscompares++; $display("FAIL hsat n=%0d got %0d want 1023", n, hc_m); end
                vectors++; if (hc_n !== 10'd1023) begin miscompares++; $display("FAIL hsat_lowpol n=%0d got %0d want 1023", n, hc_n); end
            end
        end
        pix(1'b1, 1'b0);
        vectors++; if (hc_m !== 10'd0) begin miscompares++; $display("FAIL hsat_restart got %0d want 0", hc_m); end
    endtask

    initial begin
        reset       = 1'b1;
        hs          = 1'b0;
        vs          = 1'b0;
        r_in        = 4'hA;
        g_in        = 4'h5;
        b_in        = 4'h3;
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_line();
        test_frame();
        test_lock();
        test_vsat();
        test_simul();
        test_hsat();
        summary();
        $finish;
    end

endmodule
